// File: rtl/idp_rx_link_07_pkg.sv
// Shared types and helpers for the IDP 7-TSV receive link.
// IBLEN07 sets the decoded data width; it defaults to 14 bits, enough for the largest decodable value.
`ifndef IBLEN07
`define IBLEN07 14
`endif

package idp_link_pkg;

    localparam int IDP_DW   = `IBLEN07;
    localparam int IDP_TSVW = 7;

    // Code-point weight carried by each TSV line; the decoded value is the sum over set lines.
    localparam int IDP_W [IDP_TSVW] = '{2, 7, 23, 89, 244, 1597, 10946};

    typedef enum logic {HUNT, LOCKED} idp_lock_e;

    typedef struct packed {
        logic [IDP_DW-1:0] data;
        logic              err;
    } idp_word_t;

    function automatic logic has_3c(input logic [IDP_TSVW-1:0] code);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j <= IDP_TSVW-3; j++) begin
            if (code[j+:3] == 3'b010 || code[j+:3] == 3'b101) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/idp_rx_link_07_if.sv
// Link-side and consumer-side signals of the IDP receive block.
// master drives the TSV codeword and consumer controls; slave is the receiver.
interface idp_rx_link_07_if
    import idp_link_pkg::*;
#(
    parameter int DW   = IDP_DW,
    parameter int TSVW = IDP_TSVW
);
    logic [TSVW-1:0] tsv;
    logic            tsv_valid;
    logic [DW-1:0]   dout_data;
    logic            dout_err;
    logic            dout_valid;
    logic            dout_ready;
    logic            link_up;
    logic            ovf;
    logic            cnt_clr;
    logic [15:0]     word_cnt;
    logic [15:0]     err_cnt;

    modport master (
        output tsv, tsv_valid, dout_ready, cnt_clr,
        input  dout_data, dout_err, dout_valid, link_up, ovf, word_cnt, err_cnt
    );

    modport slave (
        input  tsv, tsv_valid, dout_ready, cnt_clr,
        output dout_data, dout_err, dout_valid, link_up, ovf, word_cnt, err_cnt
    );
endinterface

// File: rtl/idp_rx_link_07_dec.sv
// Combinational IDP decoder: weighted sum of the active TSV lines.
module idp_rx_link_07_dec
    import idp_link_pkg::*;
#(
    parameter int DW   = IDP_DW,
    parameter int TSVW = IDP_TSVW
) (
    input  logic [TSVW-1:0] code_i,
    output logic [DW-1:0]   data_o
);
    always_comb begin
        data_o = '0;
        for (int j = 0; j < TSVW; j++) begin
            if (code_i[j]) data_o = data_o + DW'(IDP_W[j]);
        end
    end
endmodule

// File: rtl/idp_rx_link_07.sv
// IDP 7-TSV receive link: capture, decode, error flagging, lock FSM and output FIFO.
// Define IDP_RX_STATS_EN to build the saturating word_cnt/err_cnt statistics counters.
module idp_rx_link_07
    import idp_link_pkg::*;
#(
    parameter int DW      = IDP_DW,
    parameter int TSVW    = IDP_TSVW,
    parameter int DMAX    = 9999,
    parameter int FIFO_AW = 1,
    parameter int LOCK_N  = 4,
    parameter int ERR_N   = 3
) (
    input  logic             clock,
    input  logic             rst_n,
    idp_rx_link_07_if.slave  bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CLW   = $clog2(LOCK_N + 1);
    localparam int ELW   = $clog2(ERR_N + 1);

    logic [TSVW-1:0] s1_code_q;
    logic            s1_v_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_code_q <= '0;
            s1_v_q    <= 1'b0;
        end else begin
            s1_v_q <= bus.tsv_valid;
            if (bus.tsv_valid) s1_code_q <= bus.tsv;
        end
    end

    logic [DW-1:0] dec_data;
    logic          cw_err, rng_err, err;

    idp_rx_link_07_dec #(.DW(DW), .TSVW(TSVW)) u_dec (
        .code_i (s1_code_q),
        .data_o (dec_data)
    );

    assign cw_err  = has_3c(s1_code_q);
    assign rng_err = dec_data > DW'(DMAX);
    assign err     = cw_err | rng_err;

    idp_lock_e      state_q, state_d;
    logic [CLW-1:0] cln_q, cln_d;
    logic [ELW-1:0] ecnt_q, ecnt_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cln_q   <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cln_q   <= cln_d;
            ecnt_q  <= ecnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cln_d   = cln_q;
        ecnt_d  = ecnt_q;
        if (s1_v_q) begin
            case (state_q)
                HUNT: begin
                    if (err) begin
                        cln_d = '0;
                    end else if (cln_q == CLW'(LOCK_N - 1)) begin
                        state_d = LOCKED;
                        cln_d   = '0;
                    end else begin
                        cln_d = cln_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!err) begin
                        ecnt_d = '0;
                    end else if (ecnt_q == ELW'(ERR_N - 1)) begin
                        state_d = HUNT;
                        ecnt_d  = '0;
                        cln_d   = '0;
                    end else begin
                        ecnt_d = ecnt_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // FIFO with wrap-bit pointers; a push into a full FIFO is accepted only alongside a pop.
    idp_word_t        mem_q [DEPTH];
    idp_word_t        head;
    logic [FIFO_AW:0] wptr_q, rptr_q;
    logic             empty, full, push, pop, push_ok, drop, ovf_q;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                     (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign push    = s1_v_q && (state_q == LOCKED);
    assign pop     = !empty && bus.dout_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wptr_q[FIFO_AW-1:0]] <= '{data: dec_data, err: err};
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            if (bus.cnt_clr)  ovf_q <= 1'b0;
            else if (drop)    ovf_q <= 1'b1;
        end
    end

    assign head           = mem_q[rptr_q[FIFO_AW-1:0]];
    assign bus.dout_data  = empty ? '0 : head.data;
    assign bus.dout_err   = empty ? 1'b0 : head.err;
    assign bus.dout_valid = !empty;
    assign bus.link_up    = (state_q == LOCKED);
    assign bus.ovf        = ovf_q;

`ifdef IDP_RX_STATS_EN
    logic [15:0] word_cnt_q, err_cnt_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (bus.cnt_clr) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (push_ok && word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 1'b1;
            if (push && err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.word_cnt = word_cnt_q;
    assign bus.err_cnt  = err_cnt_q;
`else
    assign bus.word_cnt = '0;
    assign bus.err_cnt  = '0;
`endif

endmodule

// File: tb/tb_idp_rx_link_07.sv
// Bench for idp_rx_link_07: decode vector table, directed lock/FIFO/reset sequences,
// and randomized traffic compared each cycle against a queue-based reference model.
module tb_idp_rx_link_07;
    localparam int DEPTH  = 2;
    localparam int LOCK_N = 4;
    localparam int ERR_N  = 3;
    localparam int DMAX   = 9999;
    localparam int WT [7] = '{2, 7, 23, 89, 244, 1597, 10946};

    typedef struct {int data; bit err;} wrd_t;
    typedef struct {logic [6:0] code; int data; bit err;} vec_t;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    idp_rx_link_07_if bus_if ();
    idp_rx_link_07 dut (.clock(clock), .rst_n(rst_n), .bus(bus_if));

    int total = 0;
    int bad   = 0;

    // reference model state
    bit         m_locked;
    int         m_cln, m_erun, m_wcnt, m_ecnt;
    bit         m_pv;
    logic [6:0] m_pc;
    bit         m_ovf;
    wrd_t       m_q [$];
    logic [6:0] pool [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Transmit-side view of a codeword: its value and whether the receiver must flag it.
    function automatic bit ref_eval(input logic [6:0] c, output int val);
        bit alt;
        alt = 1'b0;
        val = 0;
        for (int j = 0; j < 7; j++) if (c[j]) val += WT[j];
        for (int j = 0; j < 5; j++) if (c[j] != c[j+1] && c[j+1] != c[j+2]) alt = 1'b1;
        return alt || (val > DMAX);
    endfunction

    // Transmit encoder: the clean codeword carrying a given value.
    function automatic logic [6:0] enc(input int value);
        int v;
        foreach (pool[i]) begin
            void'(ref_eval(pool[i], v));
            if (v == value) return pool[i];
        end
        return 7'd0;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_cln = 0; m_erun = 0; m_wcnt = 0; m_ecnt = 0;
        m_pv = 0; m_pc = '0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input bit v, input logic [6:0] c, input bit rdy, input bit clr);
        bit   pop, e;
        int   val;
        wrd_t w;
        pop = (m_q.size() > 0) && rdy;
        if (pop) m_q.delete(0);
        if (m_pv) begin
            e = ref_eval(m_pc, val);
            if (m_locked) begin
                if (m_q.size() < DEPTH) begin
                    w.data = val; w.err = e;
                    m_q.push_back(w);
                    if (m_wcnt < 65535) m_wcnt++;
                end else begin
                    m_ovf = 1;
                end
                if (e && m_ecnt < 65535) m_ecnt++;
                m_erun = e ? m_erun + 1 : 0;
                if (m_erun == ERR_N) begin
                    m_locked = 0; m_erun = 0; m_cln = 0;
                end
            end else begin
                m_cln = e ? 0 : m_cln + 1;
                if (m_cln == LOCK_N) begin
                    m_locked = 1; m_cln = 0;
                end
            end
        end
        if (clr) begin
            m_ovf = 0; m_wcnt = 0; m_ecnt = 0;
        end
        m_pv = v;
        m_pc = c;
    endtask

    task automatic cmp_model();
        int ew, ee;
`ifdef IDP_RX_STATS_EN
        ew = m_wcnt; ee = m_ecnt;
`else
        ew = 0; ee = 0;
`endif
        check("m_valid", bus_if.dout_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("m_data", bus_if.dout_data, m_q[0].data);
            check("m_err", bus_if.dout_err, m_q[0].err);
        end
        check("m_link", bus_if.link_up, m_locked);
        check("m_ovf", bus_if.ovf, m_ovf);
        check("m_wcnt", bus_if.word_cnt, ew);
        check("m_ecnt", bus_if.err_cnt, ee);
    endtask

    task automatic drive(input bit v, input logic [6:0] c, input bit rdy, input bit clr);
        bus_if.tsv_valid  = v;
        bus_if.tsv        = c;
        bus_if.dout_ready = rdy;
        bus_if.cnt_clr    = clr;
    endtask

    task automatic tick();
        bit         v, rdy, clr;
        logic [6:0] c;
        v = bus_if.tsv_valid; c = bus_if.tsv; rdy = bus_if.dout_ready; clr = bus_if.cnt_clr;
        @(posedge clock);
        if (!rst_n) model_reset();
        else        model_edge(v, c, rdy, clr);
        #1;
        cmp_model();
    endtask

    task automatic lock_up(input logic [6:0] c);
        for (int i = 0; i < LOCK_N; i++) begin
            drive(1, c, 1, 0); tick();
        end
        drive(0, c, 1, 0); tick(); tick(); tick();
        check("relock_link", bus_if.link_up, 1);
    endtask

    initial begin
        vec_t       tbl [12];
        logic [6:0] c356, rc;
        int         v;
        bit         rv, rr, rcl;

        for (int c = 0; c < 128; c++) if (!ref_eval(7'(c), v)) pool.push_back(7'(c));
        model_reset();
        drive(0, 7'd0, 1, 0);
        #1;
        check("rst_valid", bus_if.dout_valid, 0);
        check("rst_link", bus_if.link_up, 0);
        check("rst_ovf", bus_if.ovf, 0);
        check("rst_data", bus_if.dout_data, 0);
        check("rst_wcnt", bus_if.word_cnt, 0);
        tick(); tick();
        rst_n = 1'b1;

        // first lock and first pushed word
        c356 = enc(356);
        for (int i = 0; i < 5; i++) begin
            drive(1, c356, 1, 0); tick();
            if (i == 3) check("t1_not_locked", bus_if.link_up, 0);
        end
        check("t1_link_up", bus_if.link_up, 1);
        check("t1_no_push_yet", bus_if.dout_valid, 0);
        drive(0, c356, 1, 0); tick();
        check("t1_valid", bus_if.dout_valid, 1);
        check("t1_data", bus_if.dout_data, 356);
        check("t1_err", bus_if.dout_err, 0);

        tbl = '{'{7'b0011100,   356, 1'b0}, '{7'b0101100,  1709, 1'b1},
                '{7'b0000000,     0, 1'b0}, '{7'b1100000, 12543, 1'b1},
                '{7'b1111111, 12908, 1'b1}, '{7'b0000011,     9, 1'b0},
                '{7'b0000010,     7, 1'b1}, '{7'b0111110,  1960, 1'b0},
                '{7'b1000000, 10946, 1'b1}, '{7'b0011000,   333, 1'b0},
                '{7'b0110000,  1841, 1'b0}, '{7'b0000001,     2, 1'b0}};
        for (int i = 0; i < 12; i++) begin
            drive(1, tbl[i].code, 1, 0); tick();
            drive(0, tbl[i].code, 1, 0); tick();
            check($sformatf("vec%0d_valid", i), bus_if.dout_valid, 1);
            check($sformatf("vec%0d_data", i), bus_if.dout_data, tbl[i].data);
            check($sformatf("vec%0d_err", i), bus_if.dout_err, tbl[i].err);
            check($sformatf("vec%0d_link", i), bus_if.link_up, 1);
        end

        // three errored words in a row drop lock; the third is still pushed
        drive(1, 7'b0101100, 1, 0); tick(); tick(); tick();
        check("t2_still_locked", bus_if.link_up, 1);
        drive(1, c356, 1, 0); tick();
        check("t2_unlocked", bus_if.link_up, 0);
        check("t2_last_pushed", bus_if.dout_valid, 1);
        check("t2_last_err", bus_if.dout_err, 1);
        drive(0, c356, 1, 0); tick();
        check("t2_hunt_no_push", bus_if.dout_valid, 0);
        lock_up(c356);

        // overflow with stalled consumer, then clear
        drive(1, c356, 0, 0); tick();
        drive(1, 7'b0011000, 0, 0); tick();
        drive(1, 7'b0000001, 0, 0); tick();
        drive(0, 7'd0, 0, 0); tick();
        check("t3_ovf", bus_if.ovf, 1);
        check("t3_head", bus_if.dout_data, 356);
        tick();
        check("t3_hold", bus_if.dout_data, 356);
        drive(0, 7'd0, 0, 1); tick();
        drive(0, 7'd0, 0, 0);
        check("t3_ovf_clr", bus_if.ovf, 0);
        check("t3_still_full", bus_if.dout_valid, 1);

        // push and pop together while full
        drive(1, 7'b0110000, 0, 0); tick();
        drive(0, 7'd0, 1, 0); tick();
        check("t4_no_ovf", bus_if.ovf, 0);
        check("t4_head1", bus_if.dout_data, 333);
        tick();
        check("t4_head2", bus_if.dout_data, 1841);
        tick();
        check("t4_empty", bus_if.dout_valid, 0);

        // asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) begin
            drive(1, pool[$urandom_range(0, pool.size() - 1)], 1, 0); tick();
        end
        #3 rst_n = 1'b0;
        #1;
        check("t5_valid0", bus_if.dout_valid, 0);
        check("t5_link0", bus_if.link_up, 0);
        check("t5_data0", bus_if.dout_data, 0);
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < LOCK_N; i++) begin
            drive(1, c356, 1, 0); tick();
        end
        check("t5_needs_lockn", bus_if.link_up, 0);
        drive(0, c356, 1, 0); tick();
        check("t5_relocked", bus_if.link_up, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rv  = ($urandom_range(0, 3) != 0);
            rc  = ($urandom_range(0, 99) < 85) ? pool[$urandom_range(0, pool.size() - 1)]
                                               : 7'($urandom_range(0, 127));
            rr  = ($urandom_range(0, 9) < 7);
            rcl = ($urandom_range(0, 99) == 0);
            drive(rv, rc, rr, rcl); tick();
        end

        // counter saturation
        drive(0, 7'd0, 1, 1); tick();
        for (int i = 0; i < 65600; i++) begin
            drive(1, c356, 1, 0); tick();
        end
        drive(0, 7'd0, 1, 0); tick();
`ifdef IDP_RX_STATS_EN
        check("t6_wcnt_sat", bus_if.word_cnt, 16'hFFFF);
`else
        check("t6_wcnt_off", bus_if.word_cnt, 0);
`endif
        check("t6_ecnt", bus_if.err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
